// File: rtl/bitmap_pkg.sv
// Shared constants and FSM state encoding for the bitmap read-modify-write arbiter.
package bitmap_pkg;
    localparam int ROW_W_DEF  = 9;
    localparam int COL_W_DEF  = 9;
    localparam int WORD_W_DEF = 32;
    localparam int ADDR_W_DEF = ROW_W_DEF + COL_W_DEF - $clog2(WORD_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        MOD  = 2'd2,
        WR   = 2'd3
    } state_t;
endpackage

// File: rtl/bitmap_rmw_arbiter_if.sv
// Requester and BRAM signal bundle for the bitmap arbiter; slave = arbiter side.
interface bitmap_rmw_arbiter_if #(
    parameter int ROW_W  = bitmap_pkg::ROW_W_DEF,
    parameter int COL_W  = bitmap_pkg::COL_W_DEF,
    parameter int WORD_W = bitmap_pkg::WORD_W_DEF
);
    import bitmap_pkg::*;

    localparam int ADDR_W = ROW_W + COL_W - $clog2(WORD_W);

    logic              i_req_a;
    logic              i_req_b;
    logic [ROW_W-1:0]  i_row_a;
    logic [ROW_W-1:0]  i_row_b;
    logic [COL_W-1:0]  i_col_a;
    logic [COL_W-1:0]  i_col_b;
    logic              i_val_a;
    logic              i_val_b;
    logic              o_gnt_a;
    logic              o_gnt_b;
    logic              o_bram_en;
    logic              o_bram_we;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [WORD_W-1:0] o_bram_wdata;
    logic [WORD_W-1:0] i_bram_rdata;
    logic              o_busy;

    modport slave (
        input  i_req_a, i_req_b, i_row_a, i_row_b, i_col_a, i_col_b,
               i_val_a, i_val_b, i_bram_rdata,
        output o_gnt_a, o_gnt_b, o_bram_en, o_bram_we, o_bram_addr,
               o_bram_wdata, o_busy
    );

    modport master (
        output i_req_a, i_req_b, i_row_a, i_row_b, i_col_a, i_col_b,
               i_val_a, i_val_b, i_bram_rdata,
        input  o_gnt_a, o_gnt_b, o_bram_en, o_bram_we, o_bram_addr,
               o_bram_wdata, o_busy
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and moves only on accept.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic accept,
    output logic win_a,
    output logic win_b
);
    logic last_b;

    // On a tie the requester that did not win last time goes first.
    assign win_a = req_a & (~req_b | last_b);
    assign win_b = req_b & ~win_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (accept) begin
            last_b <= win_b;
        end
    end
endmodule

// File: rtl/bitmap_rmw_arbiter.sv
// Arbitrates two single-pixel writers onto one 1-bit-per-pixel bitmap BRAM
// using a three-cycle read-modify-write (RD, MOD, WR).
module bitmap_rmw_arbiter
    import bitmap_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int COL_W  = COL_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    bitmap_rmw_arbiter_if.slave bus
);
    localparam int BIT_W  = $clog2(WORD_W);
    localparam int ADDR_W = ROW_W + COL_W - BIT_W;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              win_a;
    logic              win_b;
    logic [ADDR_W-1:0] addr_sel;
    logic [BIT_W-1:0]  bit_sel;
    logic              val_sel;
    logic [BIT_W-1:0]  bit_q;
    logic              val_q;
    logic [WORD_W-1:0] wdata_mod;

    rr_arb2 u_arb (
        .clk    (i_clk),
        .rst_n  (i_rstn),
        .req_a  (bus.i_req_a),
        .req_b  (bus.i_req_b),
        .accept (accept),
        .win_a  (win_a),
        .win_b  (win_b)
    );

    always_comb begin
        accept     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.i_req_a || bus.i_req_b) begin
                    accept     = 1'b1;
                    state_next = RD;
                end
            end
            RD:  state_next = MOD;
            MOD: state_next = WR;
            WR: begin
                if (bus.i_req_a || bus.i_req_b) begin
                    accept     = 1'b1;
                    state_next = RD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Word address is the row followed by the upper column bits; the low column bits pick the bit.
    always_comb begin
        if (win_b) begin
            addr_sel = {bus.i_row_b, bus.i_col_b[COL_W-1:BIT_W]};
            bit_sel  = bus.i_col_b[BIT_W-1:0];
            val_sel  = bus.i_val_b;
        end else begin
            addr_sel = {bus.i_row_a, bus.i_col_a[COL_W-1:BIT_W]};
            bit_sel  = bus.i_col_a[BIT_W-1:0];
            val_sel  = bus.i_val_a;
        end
    end

    always_comb begin
        wdata_mod        = bus.i_bram_rdata;
        wdata_mod[bit_q] = val_q;
    end

    // Every output is a flop loaded from the next-state decode, so it lines up with the state.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_gnt_a      <= 1'b0;
            bus.o_gnt_b      <= 1'b0;
            bus.o_bram_en    <= 1'b0;
            bus.o_bram_we    <= 1'b0;
            bus.o_bram_addr  <= '0;
            bus.o_bram_wdata <= '0;
            bus.o_busy       <= 1'b0;
            bit_q            <= '0;
            val_q            <= 1'b0;
        end else begin
            bus.o_gnt_a   <= accept & win_a;
            bus.o_gnt_b   <= accept & win_b;
            bus.o_bram_en <= (state_next == RD) || (state_next == WR);
            bus.o_bram_we <= (state_next == WR);
            bus.o_busy    <= (state_next != IDLE);
            if (accept) begin
                bus.o_bram_addr <= addr_sel;
                bit_q           <= bit_sel;
                val_q           <= val_sel;
            end
            if (state == MOD) begin
                bus.o_bram_wdata <= wdata_mod;
            end
        end
    end
endmodule

// File: tb/tb_bitmap_rmw_arbiter.sv
// Directed bench for bitmap_rmw_arbiter: stimulus pushes expected grants/writes, a monitor checks them.
module tb_bitmap_rmw_arbiter;
    import bitmap_pkg::*;

    typedef struct {
        bit          is_b;
        logic [12:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_gnt_cyc = -1;
    bit   spacing_on = 1'b0;
    exp_t sb[$];

    logic        poke_en = 1'b0;
    logic [12:0] poke_addr = '0;
    logic [31:0] poke_data = '0;
    logic [31:0] mem [8192];

    bitmap_rmw_arbiter_if #(.ROW_W(9), .COL_W(9), .WORD_W(32)) bus ();

    bitmap_rmw_arbiter #(.ROW_W(9), .COL_W(9), .WORD_W(32)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one-cycle read latency, write on the edge ending the WR cycle.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (bus.o_bram_en) begin
            if (bus.o_bram_we) mem[bus.o_bram_addr] <= bus.o_bram_wdata;
            else               bus.i_bram_rdata <= mem[bus.o_bram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.o_gnt_a || bus.o_gnt_b) begin
                check("gnt_exclusive", 64'(bus.o_gnt_a & bus.o_gnt_b), 64'h0);
                check("gnt_expected", 64'(sb.size() > 0), 64'h1);
                if (sb.size() > 0) begin
                    check("gnt_who", 64'(bus.o_gnt_b), 64'(sb[0].is_b));
                    check("rd_addr", 64'(bus.o_bram_addr), 64'(sb[0].addr));
                    check("rd_strobe", 64'({bus.o_bram_en, bus.o_bram_we}), 64'h2);
                end
                if (spacing_on) begin
                    if (last_gnt_cyc >= 0) check("gnt_spacing", 64'(cyc - last_gnt_cyc), 64'h3);
                    last_gnt_cyc = cyc;
                end
            end
            if (bus.o_bram_en && bus.o_bram_we) begin
                check("wr_expected", 64'(sb.size() > 0), 64'h1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", 64'(bus.o_bram_addr), 64'(e.addr));
                    check("wr_wdata", 64'(bus.o_bram_wdata), 64'(e.wdata));
                end
            end
        end
    end

    task automatic poke(input logic [12:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic wait_gnt(input bit is_b, input string name);
        int n = 0;
        while (!(is_b ? bus.o_gnt_b : bus.o_gnt_a) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < 30), 64'h1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.o_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < 40), 64'h1);
    endtask

    task automatic set_a(input logic [8:0] r, input logic [8:0] c, input logic v);
        bus.i_row_a = r; bus.i_col_a = c; bus.i_val_a = v;
    endtask

    task automatic set_b(input logic [8:0] r, input logic [8:0] c, input logic v);
        bus.i_row_b = r; bus.i_col_b = c; bus.i_val_b = v;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_en_we"}, 64'({bus.o_bram_en, bus.o_bram_we}), 64'h0);
        check({name, "_gnt"}, 64'({bus.o_gnt_a, bus.o_gnt_b}), 64'h0);
        check({name, "_busy"}, 64'(bus.o_busy), 64'h0);
        check({name, "_addr"}, 64'(bus.o_bram_addr), 64'h0);
        check({name, "_wdata"}, 64'(bus.o_bram_wdata), 64'h0);
    endtask

    initial begin
        bus.i_req_a = 1'b0;
        bus.i_req_b = 1'b0;
        set_a(9'd0, 9'd0, 1'b0);
        set_b(9'd0, 9'd0, 1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        // Idle: nothing requested, nothing happens.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_en", 64'(bus.o_bram_en), 64'h0);
            check("idle_busy", 64'(bus.o_busy), 64'h0);
        end

        // A sets row 3 col 37.
        poke(13'h031, 32'h0);
        sb.push_back('{1'b0, 13'h031, 32'h0000_0020});
        set_a(9'd3, 9'd37, 1'b1);
        bus.i_req_a = 1'b1;
        wait_gnt(1'b0, "t1_gnt_a");
        bus.i_req_a = 1'b0;
        @(negedge clk);
        check("t1_gnt_pulse", 64'({bus.o_gnt_a, bus.o_gnt_b}), 64'h0);
        wait_idle("t1_idle");

        // B clears the last pixel of a full word.
        poke(13'h1FFF, 32'hFFFF_FFFF);
        sb.push_back('{1'b1, 13'h1FFF, 32'h7FFF_FFFF});
        set_b(9'd511, 9'd511, 1'b0);
        bus.i_req_b = 1'b1;
        wait_gnt(1'b1, "t2_gnt_b");
        bus.i_req_b = 1'b0;
        wait_idle("t2_idle");

        // Both held from reset: A,B,A,B at 3-cycle spacing.
        poke(13'h010, 32'h0);
        poke(13'h020, 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        set_a(9'd1, 9'd0, 1'b1);
        set_b(9'd2, 9'd0, 1'b1);
        bus.i_req_a = 1'b1;
        bus.i_req_b = 1'b1;
        sb.push_back('{1'b0, 13'h010, 32'h1});
        sb.push_back('{1'b1, 13'h020, 32'h1});
        sb.push_back('{1'b0, 13'h010, 32'h1});
        sb.push_back('{1'b1, 13'h020, 32'h1});
        spacing_on = 1'b1;
        last_gnt_cyc = -1;
        @(negedge clk);
        rstn = 1'b1;
        wait_gnt(1'b0, "t3_gnt1");
        wait_gnt(1'b1, "t3_gnt2");
        wait_gnt(1'b0, "t3_gnt3");
        wait_gnt(1'b1, "t3_gnt4");
        bus.i_req_a = 1'b0;
        bus.i_req_b = 1'b0;
        wait_idle("t3_idle");
        spacing_on = 1'b0;

        // Same word back-to-back: A sets col 0, then B sets col 1 and must see A's write.
        poke(13'h000, 32'h0);
        set_a(9'd0, 9'd0, 1'b1);
        set_b(9'd0, 9'd1, 1'b1);
        sb.push_back('{1'b0, 13'h000, 32'h1});
        sb.push_back('{1'b1, 13'h000, 32'h3});
        bus.i_req_a = 1'b1;
        bus.i_req_b = 1'b1;
        wait_gnt(1'b0, "t4_gnt_a");
        bus.i_req_a = 1'b0;
        wait_gnt(1'b1, "t4_gnt_b");
        bus.i_req_b = 1'b0;
        wait_idle("t4_idle");
        check("t4_mem", 64'(mem[0]), 64'h3);

        // Reset during MOD aborts the write; a later request completes.
        poke(13'h040, 32'h0);
        set_a(9'd4, 9'd0, 1'b1);
        sb.push_back('{1'b0, 13'h040, 32'h1});
        bus.i_req_a = 1'b1;
        wait_gnt(1'b0, "t5_gnt_a");
        bus.i_req_a = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_all_zero("t5_abort");
        sb.delete();
        repeat (2) @(negedge clk);
        check("t5_busy_held", 64'(bus.o_busy), 64'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_no_write", 64'(mem[13'h040]), 64'h0);
        sb.push_back('{1'b0, 13'h040, 32'h1});
        bus.i_req_a = 1'b1;
        wait_gnt(1'b0, "t5_regnt_a");
        bus.i_req_a = 1'b0;
        wait_idle("t5_idle");
        @(negedge clk);
        check("t5_mem", 64'(mem[13'h040]), 64'h1);

        check("sb_empty", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bitmap_rmw_arbiter.md
BITMAP_RMW_ARBITER -- requirements
Module: bitmap_rmw_arbiter

Interface
REQ-001 SHALL have parameter ROW_W, default 9, pixel row index width.
REQ-002 SHALL have parameter COL_W, default 9, pixel column index width.
REQ-003 SHALL have parameter WORD_W, default 32, bitmap BRAM word width, power of two; ADDR_W = ROW_W + COL_W - log2(WORD_W) (default 13).
REQ-004 SHALL have ports: i_clk  in  1  clock; i_rstn  in  1  reset. One clock, all logic on rising i_clk; reset asynchronous, active-low.
REQ-005 SHALL have ports i_req_a, i_req_b  in  1  write request from requester A / B.
REQ-006 SHALL have ports i_row_a, i_row_b  in  ROW_W  target pixel row; i_col_a, i_col_b  in  COL_W  target pixel column.
REQ-007 SHALL have ports i_val_a, i_val_b  in  1  bit value to write (1 = set, 0 = clear).
REQ-008 SHALL have ports o_gnt_a, o_gnt_b  out  1  one-cycle pulse, request accepted, operands latched.
REQ-009 SHALL have ports o_bram_en  out  1  BRAM enable; o_bram_we  out  1  BRAM write enable; o_bram_addr  out  ADDR_W  word address; o_bram_wdata  out  WORD_W  write data.
REQ-010 SHALL have port i_bram_rdata  in  WORD_W  read data, valid exactly one cycle after the cycle with o_bram_en=1, o_bram_we=0.
REQ-011 SHALL have port o_busy  out  1  high whenever state is not IDLE.

Function
REQ-012 SHALL perform a single-bit read-modify-write into a packed 1-bit-per-pixel bitmap for each granted request.
REQ-013 SHALL compute word address = {row, col[COL_W-1:log2(WORD_W)]}, i.e. row*16 + col/32 at defaults; bit index = col[log2(WORD_W)-1:0], LSB = lowest column.
REQ-014 SHALL use FSM states IDLE, RD, MOD, WR.
REQ-015 SHALL, in IDLE or WR, accept a request when i_req_a or i_req_b is high; on that edge it latches the winner's address, bit index and value and enters RD; otherwise WR goes to IDLE.
REQ-016 SHALL drive, in RD: o_gnt_<winner>=1, o_bram_en=1, o_bram_we=0, o_bram_addr=latched address.
REQ-017 SHALL, in MOD, with all BRAM strobes low, register o_bram_wdata = i_bram_rdata with only the indexed bit replaced by the latched value.
REQ-018 SHALL drive, in WR: o_bram_en=1, o_bram_we=1, same address, registered wdata.
REQ-019 SHALL complete each operation in 3 cycles (RD, MOD, WR); back-to-back requests sustain one write per 3 cycles via WR->RD.
REQ-020 SHALL arbitrate round-robin: a single request wins; on simultaneous requests the non-last-granted requester wins; last-granted pointer resets to B, so A wins the first tie.
REQ-021 SHALL treat i_req_x as level: requester holds req and operands until it sees its o_gnt_x, then drops or changes them the next cycle; requests raised in RD or MOD are ignored until WR/IDLE.
REQ-022 SHALL guarantee that a WR to word W followed by RD of W reads the new data (write edge precedes read edge); no forwarding is required.
REQ-023 SHALL drive all outputs from registers; o_gnt_a and o_gnt_b are never high together.

Reset
REQ-024 SHALL, on i_rstn low, immediately set: state IDLE, o_gnt_a/b=0, o_bram_en=0, o_bram_we=0, o_bram_addr=0, o_bram_wdata=0, o_busy=0, RR pointer=B.
REQ-025 SHALL abort any in-flight operation on reset mid-operation; no write is issued; the operation is lost and requester must re-request.

Structure
REQ-026 SHALL place the state enum and the default ROW_W/COL_W/WORD_W/ADDR_W constants in shared package bitmap_pkg.
REQ-027 SHALL implement arbitration in sub-module rr_arb2 (2-way round-robin, pointer update on accept).

Verification
REQ-028 Bench SHALL drive: A req row=3 col=37 val=1, BRAM word 0x31=0x0 -> gnt_a one cycle; RD addr 0x031; WR addr 0x031 wdata 0x00000020.
REQ-029 Bench SHALL drive: B req row=511 col=511 val=0, word 0x1FFF=0xFFFFFFFF -> WR addr 0x1FFF wdata 0x7FFFFFFF.
REQ-030 Bench SHALL hold A and B continuously from reset -> grants alternate A,B,A,B at 3-cycle spacing; never both high.
REQ-031 Bench SHALL drive: A sets col 0 then B sets col 1 on the same word 0x000 back-to-back, initial 0x0 -> second WR wdata 0x00000003.
REQ-032 Bench SHALL drop i_rstn during MOD -> all outputs 0 next sample, no we=1 issued, busy=0; following request completes normally.
REQ-033 Bench SHALL check idle: no requests -> o_bram_en=0, o_busy=0 indefinitely.
